instruction_fetch_unit: RTL and testbench

//  Requester side of the instruction-memory interface: owns the program counter, drives
//  pc_address into the combinational instruction memory and captures the returned 8-bit

---
 rtl/instruction_fetch_unit.sv | 112 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the combinational instruction
// memory and holds the fetched instruction for decode behind a valid/ready slot.
module instruction_fetch_unit #(
    parameter int unsigned         ADDR_W      = 8,
    parameter int unsigned         INSTR_W     = 8,
    parameter int unsigned         PC_STEP     = 2,
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
    parameter logic [INSTR_W-1:0]  HALT_OPCODE = INSTR_W'(8'hFF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    output logic [ADDR_W-1:0]  pc_address,
    input  logic [INSTR_W-1:0] mem_instr,
    input  logic               branch_valid,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALT
    } state_t;

    // Halfword-aligned targets when instructions are two bytes apart
    localparam logic [ADDR_W-1:0] TGT_MASK = (PC_STEP == 2) ?
        {{(ADDR_W-1){1'b1}}, 1'b0} : {ADDR_W{1'b1}};

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_nxt;
    logic                 r_valid;
    logic                 w_valid_nxt;
    logic [INSTR_W-1:0]   r_instr;
    logic [INSTR_W-1:0]   w_instr_nxt;
    logic [ADDR_W-1:0]    r_ipc;
    logic [ADDR_W-1:0]    w_ipc_nxt;
    logic                 w_slot_free;
    logic                 w_fetch;
    logic                 w_is_halt;
    logic [ADDR_W-1:0]    w_target;

    assign w_slot_free = !r_valid || instr_ready;
    assign w_is_halt   = (mem_instr == HALT_OPCODE);
    assign w_target    = branch_target & TGT_MASK;
    assign w_fetch     = fetch_en && (r_state != S_HALT) &&
                         w_slot_free && !branch_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_ipc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            r_instr <= w_instr_nxt;
            r_ipc   <= w_ipc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_instr_nxt = r_instr;
        w_ipc_nxt   = r_ipc;
        unique case (1'b1)
            branch_valid: begin
                // Redirect flushes the slot even if decode is stalled
                w_pc_nxt    = w_target;
                w_valid_nxt = 1'b0;
                w_state_nxt = fetch_en ? S_FETCH : S_IDLE;
            end
            w_fetch: begin
                w_instr_nxt = mem_instr;
                w_ipc_nxt   = r_pc;
                w_valid_nxt = 1'b1;
                if (w_is_halt) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_pc_nxt    = r_pc + ADDR_W'(PC_STEP);
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                if (w_slot_free) begin
                    w_valid_nxt = 1'b0;
                end
                if (r_state != S_HALT) begin
                    w_state_nxt = fetch_en ? S_FETCH : S_IDLE;
                end
            end
        endcase
    end

    assign pc_address  = r_pc;
    assign instr_valid = r_valid;
    assign instr_out   = r_instr;
    assign instr_pc    = r_ipc;
    assign halted      = (r_state == S_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: two instances, one with
// RESET_PC=0 and one with RESET_PC=8'hFE for address wrap.
module tb_instruction_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       fetch_en;
    logic       branch_valid;
    logic [7:0] branch_target;
    logic       instr_ready;

    logic [7:0] pc0, iout0, ipc0, mi0;
    logic       v0, h0;
    logic [7:0] pc1, iout1, ipc1, mi1;
    logic       v1, h1;

    logic [7:0] mem [256];

    int n_vec;
    int n_err;

    wire [25:0] full0 = {v0, h0, pc0, ipc0, iout0};
    wire [9:0]  ctl0  = {v0, h0, pc0};
    wire [25:0] full1 = {v1, h1, pc1, ipc1, iout1};
    wire [9:0]  ctl1  = {v1, h1, pc1};

    assign mi0 = mem[pc0];
    assign mi1 = mem[pc1];

    instruction_fetch_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .pc_address(pc0), .mem_instr(mi0),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(v0), .instr_out(iout0), .instr_pc(ipc0),
        .instr_ready(instr_ready), .halted(h0)
    );

    instruction_fetch_unit #(.RESET_PC(8'hFE)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .pc_address(pc1), .mem_instr(mi1),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(v1), .instr_out(iout1), .instr_pc(ipc1),
        .instr_ready(instr_ready), .halted(h1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        branch_valid = 1'b0;
        branch_target = 8'h00;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (full0 !== 26'h0) begin
            $display("FAIL reset_state: got %h want %h", full0, 26'h0);
            n_err++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        logic [25:0] e;
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        n_vec++;
        if (ctl0 !== {1'b0, 1'b0, 8'h00}) begin
            $display("FAIL seq_start: got %h want %h", ctl0, 10'h000);
            n_err++;
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e = {1'b1, 1'b0, 8'(2*k), 8'(2*k-2), 8'(2*k-2) ^ 8'hA5};
            n_vec++;
            if (full0 !== e) begin
                $display("FAIL seq_%0d: got %h want %h", k, full0, e);
                n_err++;
            end
        end
    endtask

    task automatic test_stall();
        branch_valid = 1'b1;
        branch_target = 8'h04;
        @(negedge clk);
        n_vec++;
        if (ctl0 !== {1'b0, 1'b0, 8'h04}) begin
            $display("FAIL stall_redirect: got %h want %h", ctl0, {2'b00, 8'h04});
            n_err++;
        end
        branch_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h06, 8'h04, 8'hA1}) begin
            $display("FAIL stall_pre: got %h", full0);
            n_err++;
        end
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (full0 !== {1'b1, 1'b0, 8'h06, 8'h04, 8'hA1}) begin
                $display("FAIL stall_hold_%0d: got %h want %h", k, full0,
                         {1'b1, 1'b0, 8'h06, 8'h04, 8'hA1});
                n_err++;
            end
        end
        instr_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h08, 8'h06, 8'hA3}) begin
            $display("FAIL stall_resume: got %h want %h", full0,
                     {1'b1, 1'b0, 8'h08, 8'h06, 8'hA3});
            n_err++;
        end
    endtask

    task automatic test_branch_stall();
        instr_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h08, 8'h06, 8'hA3}) begin
            $display("FAIL brs_hold: got %h", full0);
            n_err++;
        end
        branch_valid = 1'b1;
        branch_target = 8'h09;
        @(negedge clk);
        n_vec++;
        if (ctl0 !== {1'b0, 1'b0, 8'h08}) begin
            $display("FAIL brs_flush: got %h want %h", ctl0, {2'b00, 8'h08});
            n_err++;
        end
        branch_valid = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h0A, 8'h08, 8'hAD}) begin
            $display("FAIL brs_target: got %h want %h", full0,
                     {1'b1, 1'b0, 8'h0A, 8'h08, 8'hAD});
            n_err++;
        end
    endtask

    task automatic test_halt();
        mem[10] = 8'hFF;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b1, 8'h0A, 8'h0A, 8'hFF}) begin
            $display("FAIL halt_capture: got %h want %h", full0,
                     {1'b1, 1'b1, 8'h0A, 8'h0A, 8'hFF});
            n_err++;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if (ctl0 !== {1'b0, 1'b1, 8'h0A}) begin
                $display("FAIL halt_frozen_%0d: got %h want %h", k, ctl0,
                         {2'b01, 8'h0A});
                n_err++;
            end
        end
        branch_valid = 1'b1;
        branch_target = 8'h00;
        @(negedge clk);
        n_vec++;
        if (ctl0 !== {1'b0, 1'b0, 8'h00}) begin
            $display("FAIL halt_branch: got %h want %h", ctl0, 10'h000);
            n_err++;
        end
        branch_valid = 1'b0;
        mem[10] = 8'hAF;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h02, 8'h00, 8'hA5}) begin
            $display("FAIL halt_resume: got %h want %h", full0,
                     {1'b1, 1'b0, 8'h02, 8'h00, 8'hA5});
            n_err++;
        end
    endtask

    task automatic test_back_to_back_branch();
        branch_valid = 1'b1;
        branch_target = 8'h31;
        @(negedge clk);
        n_vec++;
        if (ctl0 !== {1'b0, 1'b0, 8'h30}) begin
            $display("FAIL simul_flush: got %h want %h", ctl0, {2'b00, 8'h30});
            n_err++;
        end
        branch_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h32, 8'h30, 8'h95}) begin
            $display("FAIL simul_target: got %h want %h", full0,
                     {1'b1, 1'b0, 8'h32, 8'h30, 8'h95});
            n_err++;
        end
    endtask

    task automatic test_fetch_en_drop();
        instr_ready = 1'b0;
        fetch_en = 1'b0;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h32, 8'h30, 8'h95}) begin
            $display("FAIL fen_hold: got %h", full0);
            n_err++;
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_vec++;
            if (ctl0 !== {1'b0, 1'b0, 8'h32}) begin
                $display("FAIL fen_drain_%0d: got %h want %h", k, ctl0,
                         {2'b00, 8'h32});
                n_err++;
            end
        end
        fetch_en = 1'b1;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h34, 8'h32, 8'h97}) begin
            $display("FAIL fen_resume: got %h want %h", full0,
                     {1'b1, 1'b0, 8'h34, 8'h32, 8'h97});
            n_err++;
        end
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (ctl1 !== {1'b0, 1'b0, 8'hFE}) begin
            $display("FAIL wrap_reset_pc: got %h want %h", ctl1, {2'b00, 8'hFE});
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (full1 !== {1'b1, 1'b0, 8'h00, 8'hFE, 8'h5B}) begin
            $display("FAIL wrap_fe: got %h want %h", full1,
                     {1'b1, 1'b0, 8'h00, 8'hFE, 8'h5B});
            n_err++;
        end
        @(negedge clk);
        n_vec++;
        if (full1 !== {1'b1, 1'b0, 8'h02, 8'h00, 8'hA5}) begin
            $display("FAIL wrap_00: got %h want %h", full1,
                     {1'b1, 1'b0, 8'h02, 8'h00, 8'hA5});
            n_err++;
        end
    endtask

    task automatic test_async_reset();
        instr_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h04, 8'h02, 8'hA7}) begin
            $display("FAIL arst_pre: got %h want %h", full0,
                     {1'b1, 1'b0, 8'h04, 8'h02, 8'hA7});
            n_err++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (full0 !== 26'h0) begin
            $display("FAIL arst_dut0: got %h want %h", full0, 26'h0);
            n_err++;
        end
        n_vec++;
        if (ctl1 !== {1'b0, 1'b0, 8'hFE}) begin
            $display("FAIL arst_dut1: got %h want %h", ctl1, {2'b00, 8'hFE});
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (full0 !== {1'b1, 1'b0, 8'h02, 8'h00, 8'hA5}) begin
            $display("FAIL arst_refetch: got %h want %h", full0,
                     {1'b1, 1'b0, 8'h02, 8'h00, 8'hA5});
            n_err++;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'hA5;
        end
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_halt();
        test_back_to_back_branch();
        test_fetch_en_drop();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
